// File: rtl/q15_to_drp_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : q15_to_drp_writer_pkg
//  Description : Shared types and constants for the Q1.15 -> DRP DAC writer.
//  Revision    : 1.0  initial release
// ============================================================================
package q15_to_drp_writer_pkg;

    // Write-master FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // DAC code format: 12-bit offset binary, mid-scale at 0x800
    localparam int          DAC_W   = 12;
    localparam logic [11:0] DAC_MID = 12'h800;

    // Q1.15 input format and the rounding used to drop to 12 bits
    localparam int Q15_W       = 16;
    localparam int ROUND_SHIFT = Q15_W - DAC_W;
    localparam int ROUND_BIAS  = 1 << (ROUND_SHIFT - 1);

    // Signed range of the rounded value before the offset is applied
    localparam int SAT_MAX = (1 << (DAC_W - 1)) - 1;
    localparam int SAT_MIN = -(1 << (DAC_W - 1));

endpackage : q15_to_drp_writer_pkg
`default_nettype wire

// File: rtl/q15_to_drp_writer_q15_to_offset12.sv
`default_nettype none
// ============================================================================
//  Module      : q15_to_offset12
//  Description : Combinational Q1.15 -> 12-bit offset-binary converter.
//                Round-half-up by 4 bits, saturate, then add mid-scale.
//  Revision    : 1.0  initial release
// ============================================================================
module q15_to_offset12
    import q15_to_drp_writer_pkg::*;
(
    input  logic signed [Q15_W-1:0] sample,
    output logic        [DAC_W-1:0] code
);

    localparam int c_EXT_W = Q15_W + 1;

    logic signed [c_EXT_W-1:0] w_biased;
    logic signed [c_EXT_W-1:0] w_shifted;
    logic        [DAC_W-1:0]   w_sat;

    // Sign-extend one bit so the +8 bias cannot overflow, then floor-shift
    always_comb begin
        w_biased  = $signed({sample[Q15_W-1], sample}) + $signed(c_EXT_W'(ROUND_BIAS));
        w_shifted = w_biased >>> ROUND_SHIFT;
        if (w_shifted > $signed(c_EXT_W'(SAT_MAX))) begin
            w_sat = DAC_W'(SAT_MAX);
        end else if (w_shifted < $signed(c_EXT_W'(SAT_MIN))) begin
            w_sat = DAC_W'(SAT_MIN);
        end else begin
            w_sat = w_shifted[DAC_W-1:0];
        end
        code = w_sat + DAC_MID;
    end

endmodule : q15_to_offset12
`default_nettype wire

// File: rtl/q15_to_drp_writer.sv
`default_nettype none
// ============================================================================
//  Module      : q15_to_drp_writer
//  Description : Converts Q1.15 samples to 12-bit DAC codes, buffers them in
//                a small circular buffer and writes each one to a DRP
//                register, waiting for drdy with a bounded timeout.
//  Revision    : 1.0  initial release
// ============================================================================
module q15_to_drp_writer
    import q15_to_drp_writer_pkg::*;
#(
    parameter logic [6:0] DRP_ADDR = 7'h48,
    parameter int         DEPTH    = 4,
    parameter int         TIMEOUT  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_en,
    input  logic [Q15_W-1:0]  in,
    input  logic              in_valid,
    output logic              drp_den,
    output logic              drp_dwe,
    output logic [6:0]        drp_daddr,
    output logic [15:0]       drp_di,
    input  logic              drp_drdy,
    input  logic              clr_err,
    output logic              busy,
    output logic              overflow,
    output logic              timeout_err
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_TMR_W = $clog2(TIMEOUT);

    state_t               r_state;
    logic [c_TMR_W-1:0]   r_timer;
    logic [DAC_W-1:0]     r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;

    logic [DAC_W-1:0]     w_code;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_in_fire;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_timeout;

    q15_to_offset12 u_conv (
        .sample (in),
        .code   (w_code)
    );

    // Full/empty come from the registered count only, so a pop in the same
    // cycle never frees room for a push while full
    assign w_full    = (r_count == c_CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_in_fire = clk_en & in_valid;
    assign w_push    = w_in_fire & ~w_full;
    assign w_pop     = (r_state == ST_IDLE) & ~w_empty;
    assign w_timeout = (r_state == ST_WAIT) & ~drp_drdy &
                       (r_timer == c_TMR_W'(TIMEOUT - 1));
    assign busy      = ~w_empty | (r_state != ST_IDLE);

    // Buffer storage holds converted codes; contents need no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_code;
        end
    end

    // Buffer pointers, occupancy and the sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_in_fire && w_full) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
        end
    end

    // DRP write master: IDLE pops, REQ pulses den, WAIT awaits drdy or times out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_timer   <= '0;
            drp_den   <= 1'b0;
            drp_dwe   <= 1'b0;
            drp_daddr <= '0;
            drp_di    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        drp_den   <= 1'b1;
                        drp_dwe   <= 1'b1;
                        drp_daddr <= DRP_ADDR;
                        drp_di    <= {{(16 - DAC_W){1'b0}}, r_mem[r_rd_ptr]};
                        r_state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    drp_den   <= 1'b0;
                    drp_dwe   <= 1'b0;
                    drp_daddr <= '0;
                    drp_di    <= '0;
                    r_timer   <= '0;
                    r_state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (drp_drdy || w_timeout) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer + c_TMR_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky timeout flag; a new timeout outranks a clear in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err <= 1'b0;
        end else if (w_timeout) begin
            timeout_err <= 1'b1;
        end else if (clr_err) begin
            timeout_err <= 1'b0;
        end
    end

endmodule : q15_to_drp_writer
`default_nettype wire

// File: tb/tb_q15_to_drp_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_q15_to_drp_writer
//  Description : Self-checking bench for q15_to_drp_writer with a DRP drdy
//                responder, a write monitor and an arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_q15_to_drp_writer;

    localparam int c_DEPTH   = 4;
    localparam int c_TIMEOUT = 64;

    typedef struct {
        logic [15:0] di;
        logic [6:0]  addr;
        logic        dwe;
        logic        prev;
        int          cyc;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_en;
    logic [15:0] in_s;
    logic        in_valid;
    logic        drp_den;
    logic        drp_dwe;
    logic [6:0]  drp_daddr;
    logic [15:0] drp_di;
    logic        drp_drdy = 1'b0;
    logic        clr_err;
    logic        busy;
    logic        overflow;
    logic        timeout_err;

    int          n_run  = 0;
    int          n_fail = 0;
    int          ncyc   = 0;
    logic        prev_den = 1'b0;
    wr_t         wr_q[$];
    int          rd_idx = 0;
    logic [11:0] exp_q[$];

    int          rsp_delay  = -1;
    int          rsp_cnt    = 0;
    int          force_req  = 0;
    int          force_seen = 0;

    q15_to_drp_writer #(
        .DRP_ADDR (7'h48),
        .DEPTH    (c_DEPTH),
        .TIMEOUT  (c_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk_en      (clk_en),
        .in          (in_s),
        .in_valid    (in_valid),
        .drp_den     (drp_den),
        .drp_dwe     (drp_dwe),
        .drp_daddr   (drp_daddr),
        .drp_di      (drp_di),
        .drp_drdy    (drp_drdy),
        .clr_err     (clr_err),
        .busy        (busy),
        .overflow    (overflow),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Write monitor: log every den cycle with its payload and cycle number
    always @(negedge clk) begin
        ncyc     <= ncyc + 1;
        prev_den <= drp_den;
        if (rst_n && drp_den) begin
            wr_q.push_back('{drp_di, drp_daddr, drp_dwe, prev_den, ncyc + 1});
        end
    end

    // drdy responder: answer rsp_delay cycles after den, or on explicit request
    always @(negedge clk) begin
        force_seen <= force_req;
        if (force_req != force_seen) begin
            drp_drdy <= 1'b1;
        end else if (rsp_cnt == 1) begin
            drp_drdy <= 1'b1;
        end else begin
            drp_drdy <= 1'b0;
        end
        if (rst_n && drp_den && rsp_delay > 0) begin
            rsp_cnt <= rsp_delay;
        end else if (rsp_cnt > 0) begin
            rsp_cnt <= rsp_cnt - 1;
        end
    end

    // Reference conversion: floor((x + 8) / 16), clamp to 12-bit signed, add 2048
    function automatic logic [11:0] ref_code(input logic [15:0] s);
        int v;
        int t;
        int q;
        v = int'($signed(s));
        t = v + 8;
        q = t / 16;
        if ((t % 16) != 0 && t < 0) q = q - 1;
        if (q > 2047)  q = 2047;
        if (q < -2048) q = -2048;
        return 12'(q + 2048);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_run++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] s, input logic en, input logic vld, input logic acc);
        in_s     = s;
        clk_en   = en;
        in_valid = vld;
        tick();
        clk_en   = 1'b0;
        in_valid = 1'b0;
        if (acc) exp_q.push_back(ref_code(s));
    endtask

    task automatic wait_wr(input int target, input int budget);
        int n = 0;
        while (wr_q.size() < target && n < budget) begin
            tick();
            n++;
        end
        chk("wait_for_write", 32'(wr_q.size() >= target), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        chk("wait_idle", 32'(busy), 32'd0);
    endtask

    task automatic pulse_drdy();
        force_req = force_req + 1;
        tick();
    endtask

    // Compare every logged write against the expected code stream
    task automatic drain();
        wr_t         e;
        logic [11:0] c;
        while (rd_idx < wr_q.size()) begin
            e = wr_q[rd_idx];
            rd_idx++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(e.di), 32'hFFFF_FFFF);
            end else begin
                c = exp_q.pop_front();
                chk("di",         32'(e.di),   32'({4'b0, c}));
                chk("daddr",      32'(e.addr), 32'h48);
                chk("dwe",        32'(e.dwe),  32'd1);
                chk("den_pulse",  32'(e.prev), 32'd0);
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {drp_den, drp_dwe, drp_daddr, drp_di, busy, overflow, timeout_err}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] bnd [6];
        int          base;
        int          acc_cyc;
        int          len;
        logic        en;
        logic        vld;
        logic [15:0] s;

        bnd = '{16'h8000, 16'h7FFF, 16'h0008, 16'hFFF7, 16'h0000, 16'h7FF8};

        rst_n = 1'b0; clk_en = 1'b0; in_valid = 1'b0; in_s = '0; clr_err = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset_outputs");
        rst_n = 1'b1;
        tick();

        // Single sample, drdy two cycles after den; den one cycle after accept
        rsp_delay = 2;
        base = wr_q.size();
        send(16'h0000, 1'b1, 1'b1, 1'b1);
        acc_cyc = ncyc;
        wait_wr(base + 1, 20);
        chk("first_den_latency", 32'(wr_q[base].cyc), 32'(acc_cyc + 1));
        wait_idle(50);
        drain();

        // Boundary codes back-to-back, order preserved
        rsp_delay = 1;
        for (int i = 0; i < 4; i++) send(bnd[i], 1'b1, 1'b1, 1'b1);
        wait_idle(100);
        drain();

        // Overflow: one word stalled in WAIT, four buffered, fifth dropped
        rsp_delay = -1;
        base = wr_q.size();
        send(16'h1234, 1'b1, 1'b1, 1'b1);
        wait_wr(base + 1, 20);
        for (int i = 0; i < 5; i++) send(16'(16'h0100 * (i + 1)), 1'b1, 1'b1, (i < 4));
        chk("overflow_set", 32'(overflow), 32'd1);
        chk("busy_while_full", 32'(busy), 32'd1);
        clr_err = 1'b1;
        send(16'h7000, 1'b1, 1'b1, 1'b0);
        clr_err = 1'b0;
        chk("overflow_set_beats_clr", 32'(overflow), 32'd1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("overflow_cleared", 32'(overflow), 32'd0);
        chk("no_timeout_yet", 32'(timeout_err), 32'd0);
        rsp_delay = 1;
        pulse_drdy();
        wait_idle(100);
        chk("overflow_writes", 32'(wr_q.size() - base), 32'd5);
        drain();

        // Timeout: drdy never comes; next word follows TIMEOUT+2 cycles later
        rsp_delay = -1;
        base = wr_q.size();
        send(16'h2000, 1'b1, 1'b1, 1'b1);
        send(16'hE000, 1'b1, 1'b1, 1'b1);
        wait_wr(base + 2, 200);
        chk("timeout_gap", 32'(wr_q[base + 1].cyc - wr_q[base].cyc), 32'(c_TIMEOUT + 2));
        chk("timeout_err_set", 32'(timeout_err), 32'd1);
        pulse_drdy();
        wait_idle(20);
        chk("timeout_err_sticky", 32'(timeout_err), 32'd1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("timeout_err_cleared", 32'(timeout_err), 32'd0);
        drain();

        // Reset during WAIT with three words buffered drops everything
        base = wr_q.size();
        send(16'h0400, 1'b1, 1'b1, 1'b1);
        wait_wr(base + 1, 20);
        drain();
        for (int i = 0; i < 3; i++) send(16'(16'h0800 + i), 1'b1, 1'b1, 1'b1);
        tick();
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset_outputs");
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        rd_idx = wr_q.size() < rd_idx ? rd_idx : rd_idx;
        chk("no_den_after_reset", 32'(wr_q.size()), 32'(base + 1));
        chk("idle_after_reset", 32'(busy), 32'd0);
        rsp_delay = 2;
        send(16'hC000, 1'b1, 1'b1, 1'b1);
        wait_idle(50);
        drain();

        // in_valid without clk_en is ignored; drdy in IDLE is ignored
        base = wr_q.size();
        for (int i = 0; i < 4; i++) send(16'h5555, 1'b0, 1'b1, 1'b0);
        rsp_delay = -1;
        pulse_drdy();
        repeat (3) tick();
        chk("no_accept_without_clk_en", 32'(wr_q.size()), 32'(base));
        chk("idle_after_spurious_drdy", 32'(busy), 32'd0);
        rsp_delay = 2;
        send(16'h3FFF, 1'b1, 1'b1, 1'b1);
        wait_idle(50);
        drain();

        // Randomized bursts no deeper than the buffer, random gating and drdy delay
        for (int b = 0; b < 40; b++) begin
            wait_idle(200);
            rsp_delay = int'($urandom_range(1, 4));
            len = int'($urandom_range(1, c_DEPTH));
            for (int k = 0; k < len; k++) begin
                s   = ($urandom_range(0, 3) == 0) ? bnd[$urandom_range(0, 5)] : 16'($urandom);
                en  = ($urandom_range(0, 3) != 0);
                vld = ($urandom_range(0, 3) != 0);
                send(s, en, vld, en & vld);
            end
        end
        wait_idle(200);
        drain();
        chk("expected_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("overflow_final", 32'(overflow), 32'd0);
        chk("timeout_final", 32'(timeout_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule : tb_q15_to_drp_writer
`default_nettype wire
